fact_accel: RTL and testbench

- Memory-mapped factorial accelerator on the MIPS data bus, downstream of the CPU's address decoder.
- It is selected by factorial_write_enable / read_select. Its read data feeds the readdata mux alongside dmem, GPIO and PWM.
- Software writes n, then writes go. The block computes n! iteratively with one multiply per clock, then exposes done, error and the result as readable registers.
- It runs on the 100 MHz board clock, not the 1 Hz CPU clock.

---
 rtl/fact_accel_if.sv | 15 +
 rtl/fact_accel.sv | 116 +++++++++++
 tb/tb_fact_accel.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fact_accel_if.sv
// Bus-side signals of the factorial accelerator as seen from the CPU address decoder.
// The master is the CPU/decoder; the slave is fact_accel.
interface fact_accel_if #(
  parameter int DATA_W = 32
);
  logic              we;
  logic [1:0]        a;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd;
  logic              done;
  logic              busy;

  modport master (output we, a, wd, input rd, done, busy);
  modport slave  (input we, a, wd, output rd, done, busy);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial engine: one multiply per clock.
// Exposes N, GO, STATUS and RESULT words.
module fact_accel #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic        clk,
  input  logic        reset,
  fact_accel_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [N_W-1:0]    n_reg, cnt;
  logic [DATA_W-1:0] prod, result, rd_mux;
  logic              done_r, err_r, busy_r;
  logic              go_req, n_ok;
  logic              start_ok, start_err, step, finish;

  function automatic logic [DATA_W-1:0] mul_trunc(input logic [DATA_W-1:0] p,
                                                  input logic [N_W-1:0]    c);
    logic [DATA_W+N_W-1:0] full;
    full = {{N_W{1'b0}}, p} * {{DATA_W{1'b0}}, c};
    return full[DATA_W-1:0];
  endfunction

  assign go_req = bus.we && (bus.a == 2'd1) && bus.wd[0];
  assign n_ok   = (n_reg <= N_W'(MAX_N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go_req && n_ok) state_nxt = BUSY;
      BUSY: if (cnt <= N_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ok  = 1'b0;
    start_err = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        start_ok  = go_req && n_ok;
        start_err = go_req && !n_ok;
      end
      BUSY: begin
        step   = (cnt > N_W'(1));
        finish = (cnt <= N_W'(1));
      end
      default: ;
    endcase
  end

  // cnt is a private copy of N so later N writes cannot disturb a running job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg  <= '0;
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (bus.we && (bus.a == 2'd0)) n_reg <= bus.wd[N_W-1:0];
      if (start_ok || start_err) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end
      if (start_err) begin
        err_r  <= 1'b1;
        done_r <= 1'b1;
        result <= '0;
      end
      if (start_ok) begin
        prod   <= DATA_W'(1);
        cnt    <= n_reg;
        busy_r <= 1'b1;
      end
      if (step) begin
        prod <= mul_trunc(prod, cnt);
        cnt  <= cnt - N_W'(1);
      end
      if (finish) begin
        result <= prod;
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.a)
      2'd0:    rd_mux = DATA_W'(n_reg);
      2'd1:    rd_mux = '0;
      2'd2:    rd_mux = DATA_W'({busy_r, err_r, done_r});
      default: rd_mux = result;
    endcase
  end

  assign bus.rd   = rd_mux;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_fact_accel.sv
// Bench for fact_accel: directed scenarios plus random bus traffic checked
// against a cycle-counting behavioural model of the register map.
module tb_fact_accel;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fact_accel_if #(.DATA_W(DATA_W)) bus ();

  fact_accel #(.DATA_W(DATA_W), .N_W(4), .MAX_N(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  m_n;
  logic [31:0] m_result, m_target;
  logic        m_done, m_err, m_busy;
  int          m_rem;

  function automatic logic [31:0] fact(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return {28'd0, m_n};
      2'd1:    return 32'd0;
      2'd2:    return {29'd0, m_busy, m_err, m_done};
      default: return m_result;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 4'd0; m_result = 32'd0; m_target = 32'd0;
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_rem = 0;
  endtask

  // Job finishes max(n,1) edges after the accepted GO edge.
  task automatic model_edge(input logic w, input logic [1:0] addr, input logic [31:0] d);
    if (m_busy) begin
      if (m_rem <= 1) begin
        m_busy = 1'b0; m_done = 1'b1; m_result = m_target;
      end else m_rem--;
    end else if (w && addr == 2'd1 && d[0]) begin
      m_done = 1'b0; m_err = 1'b0;
      if (m_n > 4'd12) begin
        m_err = 1'b1; m_done = 1'b1; m_result = 32'd0;
      end else begin
        m_busy = 1'b1;
        m_rem = (m_n == 4'd0) ? 1 : int'(m_n);
        m_target = fact(int'(m_n));
      end
    end
    if (w && addr == 2'd0) m_n = d[3:0];
  endtask

  task automatic cyc(input logic w, input logic [1:0] addr, input logic [31:0] d,
                     input logic [1:0] raddr);
    bus.we = w; bus.a = addr; bus.wd = d;
    #1;
    chk("rd_pre_edge", bus.rd, m_read(addr));
    @(posedge clk);
    model_edge(w, addr, d);
    #1;
    bus.we = 1'b0; bus.a = raddr;
    #1;
    chk("rd", bus.rd, m_read(raddr));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  task automatic run_n(input logic [3:0] n, input logic [31:0] exp_res, input int cycles);
    cyc(1'b1, 2'd0, {28'd0, n}, 2'd0);
    cyc(1'b1, 2'd1, 32'd1, 2'd2);
    chk("busy_after_go", 32'(bus.busy), 32'd1);
    for (int i = 0; i < cycles - 1; i++) cyc(1'b0, 2'd0, 32'd0, 2'd2);
    chk("not_done_early", 32'(bus.done), 32'd0);
    cyc(1'b0, 2'd0, 32'd0, 2'd3);
    chk("result_const", bus.rd, exp_res);
    bus.a = 2'd2; #1;
    chk("status_const", bus.rd, 32'h1);
  endtask

  initial begin
    bus.we = 1'b0; bus.a = 2'd0; bus.wd = '0;
    reset = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      bus.a = 2'(i); #1;
      chk("reset_rd", bus.rd, 32'd0);
    end
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of an N=7 job
    cyc(1'b1, 2'd0, 32'd7, 2'd0);
    cyc(1'b1, 2'd1, 32'd1, 2'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 32'd0, 2'd2);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      bus.a = 2'(i); #1;
      chk("async_reset_rd", bus.rd, 32'd0);
    end
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    chk("async_reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;

    run_n(4'd5, 32'h00000078, 5);
    run_n(4'd12, 32'h1C8CFC00, 12);
    run_n(4'd0, 32'h00000001, 1);
    run_n(4'd1, 32'h00000001, 1);

    // Error start, then a good start clears err
    cyc(1'b1, 2'd0, 32'd13, 2'd0);
    cyc(1'b1, 2'd1, 32'd1, 2'd2);
    chk("err_status", bus.rd, 32'h3);
    bus.a = 2'd3; #1;
    chk("err_result", bus.rd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd0, 32'd0, 2'd2);
      chk("err_no_busy", 32'(bus.busy), 32'd0);
    end
    run_n(4'd3, 32'h00000006, 3);

    // GO at E2 and N=2 at E3 during an N=6 job
    cyc(1'b1, 2'd0, 32'd6, 2'd0);
    cyc(1'b1, 2'd1, 32'd1, 2'd2);
    cyc(1'b0, 2'd0, 32'd0, 2'd2);
    cyc(1'b1, 2'd1, 32'd1, 2'd2);
    cyc(1'b1, 2'd0, 32'd2, 2'd0);
    cyc(1'b0, 2'd0, 32'd0, 2'd2);
    cyc(1'b0, 2'd0, 32'd0, 2'd2);
    chk("coll_not_done", 32'(bus.done), 32'd0);
    cyc(1'b0, 2'd0, 32'd0, 2'd3);
    chk("coll_result", bus.rd, 32'h000002D0);
    bus.a = 2'd0; #1;
    chk("coll_n", bus.rd, 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] d;
      op = int'($urandom_range(0, 9));
      d  = $urandom;
      if (op < 3)      cyc(1'b1, 2'd0, d, 2'($urandom_range(0, 3)));
      else if (op < 5) cyc(1'b1, 2'd1, d, 2'($urandom_range(0, 3)));
      else if (op < 6) cyc(1'b1, 2'($urandom_range(2, 3)), d, 2'($urandom_range(0, 3)));
      else             cyc(1'b0, 2'($urandom_range(0, 3)), d, 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
